// File: rtl/memory_arbiter.sv
// Two-master arbiter for the single on-chip Memory port: one transaction in flight,
// round-robin or fixed-priority grant, and a watchdog that aborts a stalled slave.
module memory_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_read_request_i,
  input  logic                  m0_write_request_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_write_data_i,
  output logic [DATA_WIDTH-1:0] m0_read_data_o,
  output logic                  m0_response_o,
  input  logic                  m1_read_request_i,
  input  logic                  m1_write_request_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_write_data_i,
  output logic [DATA_WIDTH-1:0] m1_read_data_o,
  output logic                  m1_response_o,
  output logic                  mem_read_request_o,
  output logic                  mem_write_request_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  input  logic                  mem_response_i,
  output logic                  busy_o,
  output logic                  owner_o,
  output logic                  timeout_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  rd_req_q, rd_req_d;
  logic                  wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic req0, req1, grant1, wr_sel;
  logic resp_hit, tmo_hit, done;

  always_comb begin
    req0     = m0_read_request_i | m0_write_request_i;
    req1     = m1_read_request_i | m1_write_request_i;
    // m1 wins only when alone, or on a tie when round-robin says it is m1's turn.
    grant1   = req1 & (~req0 | ((ROUND_ROBIN != 0) & ~owner_q));
    wr_sel   = grant1 ? m1_write_request_i : m0_write_request_i;
    resp_hit = (state_q == StBusy) & mem_response_i;
    tmo_hit  = (state_q == StBusy) & ~mem_response_i & (TIMEOUT_CYCLES != 0) &
               (cnt_q == CntLast);
    done     = resp_hit | tmo_hit;

    state_d  = state_q;
    owner_d  = owner_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d  = StBusy;
          owner_d  = grant1;
          wr_req_d = wr_sel;
          rd_req_d = ~wr_sel;
          addr_d   = grant1 ? m1_addr_i : m0_addr_i;
          wdata_d  = grant1 ? m1_write_data_i : m0_write_data_i;
        end
      end
      StBusy: begin
        if (done) begin
          state_d  = StDone;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d  = StIdle;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b1;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_read_request_o  = rd_req_q;
  assign mem_write_request_o = wr_req_q;
  assign mem_addr_o          = addr_q;
  assign mem_write_data_o    = wdata_q;
  assign busy_o              = (state_q == StBusy);
  assign owner_o             = owner_q;
  assign timeout_o           = tmo_hit;

  // Completion is steered combinationally so the master sees it in the Memory response cycle.
  assign m0_response_o  = done & ~owner_q;
  assign m1_response_o  = done & owner_q;
  assign m0_read_data_o = (resp_hit & ~owner_q) ? mem_read_data_i : '0;
  assign m1_read_data_o = (resp_hit & owner_q) ? mem_read_data_i : '0;

endmodule
